frame_tx: RTL

Transmit-side framer for the valid/SOP/EOP frame protocol. It accepts a frame command (beat count), pulls payload beats from an upstream source, and drives registered `o_valid`/`o_sop`/`o_eop`/`o_data` toward the frame receive path. Its output is legal by construction:
- SOP and EOP only with valid.
- No EOP without a preceding SOP.
- No second SOP before an EOP.
- No EOP as the first marker after reset.

---
 rtl/frame_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/frame_tx.sv
// frame_tx: transmit-side framer. Takes a beat-count command, pulls that many
// payload beats from upstream and emits registered valid/SOP/EOP/data beats.
// Early abort is supported. A completed-frame counter advances on every EOP.
module frame_tx #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_cmdReady,
  output logic              o_lenErr,
  input  logic              i_dataValid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_dataReady,
  input  logic              i_abort,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_aborted,
  output logic [CNT_W-1:0]  o_frameCount
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;
  logic               sop_sent_reg, sop_sent_next;

  logic               valid_reg, valid_next;
  logic               sop_reg, sop_next;
  logic               eop_reg, eop_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               len_err_reg, len_err_next;
  logic               aborted_reg, aborted_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic               xfer;
  logic               last_beat;

  // A beat moves only while ACTIVE; that is also when upstream sees ready.
  assign xfer      = (state_reg == S_ACTIVE) && i_dataValid;
  assign last_beat = (remaining_reg == LEN_W'(1));

  // State register: FSM state, beats still owed, and whether SOP went out.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      sop_sent_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      sop_sent_reg  <= sop_sent_next;
    end
  end

  // Next-state logic: command acceptance, beat accounting, abort exits.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    sop_sent_next  = sop_sent_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_start && (i_length != '0)) begin
          state_next     = S_ACTIVE;
          remaining_next = i_length;
          sop_sent_next  = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          sop_sent_next  = 1'b1;
          remaining_next = remaining_reg - LEN_W'(1);
          // Last beat wins over a coincident abort; either way the frame ends.
          if (last_beat || i_abort) begin
            state_next = S_IDLE;
          end
        end else if (i_abort) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered output beat and pulses.
  always_comb begin
    valid_next   = 1'b0;
    sop_next     = 1'b0;
    eop_next     = 1'b0;
    data_next    = '0;
    len_err_next = 1'b0;
    aborted_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        len_err_next = i_start && (i_length == '0);
      end
      S_ACTIVE: begin
        if (xfer) begin
          valid_next = 1'b1;
          data_next  = i_data;
          sop_next   = !sop_sent_reg;
          if (last_beat) begin
            eop_next = 1'b1;
          end else if (i_abort) begin
            eop_next     = 1'b1;
            aborted_next = 1'b1;
          end
        end else if (i_abort) begin
          // Only close with a terminator if the receiver has seen an SOP.
          valid_next   = sop_sent_reg;
          eop_next     = sop_sent_reg;
          aborted_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counter advances together with the EOP it counts, so both show at once.
  assign count_next = count_reg + {{(CNT_W-1){1'b0}}, eop_next};

  // Output registers: no combinational path from any input to any output.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      valid_reg   <= 1'b0;
      sop_reg     <= 1'b0;
      eop_reg     <= 1'b0;
      data_reg    <= '0;
      len_err_reg <= 1'b0;
      aborted_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      valid_reg   <= valid_next;
      sop_reg     <= sop_next;
      eop_reg     <= eop_next;
      data_reg    <= data_next;
      len_err_reg <= len_err_next;
      aborted_reg <= aborted_next;
      count_reg   <= count_next;
    end
  end

  assign o_valid      = valid_reg;
  assign o_sop        = sop_reg;
  assign o_eop        = eop_reg;
  assign o_data       = data_reg;
  assign o_lenErr     = len_err_reg;
  assign o_aborted    = aborted_reg;
  assign o_frameCount = count_reg;
  assign o_cmdReady   = (state_reg == S_IDLE);
  assign o_dataReady  = (state_reg == S_ACTIVE);

endmodule
